// File: rtl/tlb_array_pkg.sv
// -----------------------------------------------------------------------------
// tlb_defs : shared definitions for the 16-entry TLB array.
//   Holds the array geometry, the page-size encodings, the INVTLB op codes,
//   the entry record, the invalidation FSM state type and two helpers:
//   vppn_hit (page-size aware VPPN compare) and inv_pred (INVTLB selection).
// Optional feature macro used by the top: TLB_STAT_EN.
// -----------------------------------------------------------------------------
package tlb_defs;

   localparam int TLB_NUM   = 16;
   localparam int TLB_IDX_W = 4;

   localparam logic [5:0] PS_4K = 6'd12;
   localparam logic [5:0] PS_2M = 6'd21;

   localparam logic [4:0] INV_ALL0      = 5'd0;
   localparam logic [4:0] INV_ALL1      = 5'd1;
   localparam logic [4:0] INV_GLOBAL    = 5'd2;
   localparam logic [4:0] INV_NONGLOBAL = 5'd3;
   localparam logic [4:0] INV_ASID      = 5'd4;
   localparam logic [4:0] INV_ASID_VA   = 5'd5;
   localparam logic [4:0] INV_GASID_VA  = 5'd6;

   typedef struct packed {
      logic        e;
      logic [18:0] vppn;
      logic [5:0]  ps;
      logic [9:0]  asid;
      logic        g;
      logic [19:0] ppn0;
      logic [1:0]  plv0;
      logic [1:0]  mat0;
      logic        d0;
      logic        v0;
      logic [19:0] ppn1;
      logic [1:0]  plv1;
      logic [1:0]  mat1;
      logic        d1;
      logic        v1;
   } tlb_entry_t;

   typedef enum logic [1:0] {
      INV_IDLE = 2'd0,
      INV_WALK = 2'd1,
      INV_DONE = 2'd2
   } inv_state_t;

   // A 4 KB entry compares all 19 VPPN bits; anything else is treated as a
   // 2 MB pair, where the low 9 VPPN bits are inside the page.
   function automatic logic vppn_hit(input logic [18:0] ent_vppn,
                                     input logic [5:0]  ent_ps,
                                     input logic [18:0] vppn);
      if (ent_ps == PS_4K) return ent_vppn == vppn;
      return ent_vppn[18:9] == vppn[18:9];
   endfunction

   // Selection rule for one entry under an INVTLB op. E is checked by the
   // caller only implicitly: clearing an already-clear E is harmless.
   function automatic logic inv_pred(input tlb_entry_t  ent,
                                     input logic [4:0]  op,
                                     input logic [9:0]  asid,
                                     input logic [18:0] vppn);
      logic asid_m;
      logic va_m;
      asid_m = (ent.asid == asid);
      va_m   = vppn_hit(ent.vppn, ent.ps, vppn);
      case (op)
         INV_ALL0, INV_ALL1: return 1'b1;
         INV_GLOBAL:         return ent.g;
         INV_NONGLOBAL:      return !ent.g;
         INV_ASID:           return !ent.g && asid_m;
         INV_ASID_VA:        return !ent.g && asid_m && va_m;
         INV_GASID_VA:       return (ent.g || asid_m) && va_m;
         default:            return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/tlb_array_match.sv
// -----------------------------------------------------------------------------
// tlb_match : single-entry search comparator.
//   Decides whether one stored entry translates the searched VPPN/ASID and
//   which half of the even/odd page pair the access falls in.
// Ports:
//   e_i, g_i, ent_asid_i, ent_vppn_i, ent_ps_i  stored entry header
//   vppn_i, va_bit12_i, asid_i                  search key
//   match_o                                     entry hits
//   odd_o                                       1 = odd page fields apply
// -----------------------------------------------------------------------------
module tlb_match
   import tlb_defs::*;
(
   input  logic        e_i,
   input  logic        g_i,
   input  logic [9:0]  ent_asid_i,
   input  logic [18:0] ent_vppn_i,
   input  logic [5:0]  ent_ps_i,
   input  logic [18:0] vppn_i,
   input  logic        va_bit12_i,
   input  logic [9:0]  asid_i,
   output logic        match_o,
   output logic        odd_o
);

   assign match_o = e_i && (g_i || (ent_asid_i == asid_i)) &&
                    vppn_hit(ent_vppn_i, ent_ps_i, vppn_i);

   // 4 KB pairs split on VA bit 12, 2 MB pairs on VPPN bit 8 (VA bit 21).
   assign odd_o = (ent_ps_i == PS_4K) ? va_bit12_i : vppn_i[8];

endmodule

// File: rtl/tlb_array.sv
// -----------------------------------------------------------------------------
// tlb_array : 16-entry fully associative TLB with one write port, one read
//   port, two combinational search ports and an INVTLB walker.
// Ports:
//   clk, reset                       clock, async active-high reset
//   we, w_index, w_*                 write port (commits at posedge)
//   r_index -> r_*                   combinational read port
//   sN_req/vppn/va_bit12/asid        search key, N=0 fetch, N=1 mem/tlbsrch
//   sN_found/index/ppn/ps/plv/mat/d/v  search result (lowest matching index)
//   inv_req/op/asid/vppn             INVTLB command
//   inv_busy, inv_done               INVTLB status
//   stat_hit, stat_miss              s1 hit/miss cycle counters (TLB_STAT_EN)
// Optional feature: define TLB_STAT_EN to add the s1 statistics counters.
// -----------------------------------------------------------------------------
module tlb_array
   import tlb_defs::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [3:0]  w_index,
   input  logic        w_e,
   input  logic [18:0] w_vppn,
   input  logic [5:0]  w_ps,
   input  logic [9:0]  w_asid,
   input  logic        w_g,
   input  logic [19:0] w_ppn0,
   input  logic [1:0]  w_plv0,
   input  logic [1:0]  w_mat0,
   input  logic        w_d0,
   input  logic        w_v0,
   input  logic [19:0] w_ppn1,
   input  logic [1:0]  w_plv1,
   input  logic [1:0]  w_mat1,
   input  logic        w_d1,
   input  logic        w_v1,
   input  logic [3:0]  r_index,
   output logic        r_e,
   output logic [18:0] r_vppn,
   output logic [5:0]  r_ps,
   output logic [9:0]  r_asid,
   output logic        r_g,
   output logic [19:0] r_ppn0,
   output logic [1:0]  r_plv0,
   output logic [1:0]  r_mat0,
   output logic        r_d0,
   output logic        r_v0,
   output logic [19:0] r_ppn1,
   output logic [1:0]  r_plv1,
   output logic [1:0]  r_mat1,
   output logic        r_d1,
   output logic        r_v1,
   input  logic        s0_req,
   input  logic [18:0] s0_vppn,
   input  logic        s0_va_bit12,
   input  logic [9:0]  s0_asid,
   output logic        s0_found,
   output logic [3:0]  s0_index,
   output logic [19:0] s0_ppn,
   output logic [5:0]  s0_ps,
   output logic [1:0]  s0_plv,
   output logic [1:0]  s0_mat,
   output logic        s0_d,
   output logic        s0_v,
   input  logic        s1_req,
   input  logic [18:0] s1_vppn,
   input  logic        s1_va_bit12,
   input  logic [9:0]  s1_asid,
   output logic        s1_found,
   output logic [3:0]  s1_index,
   output logic [19:0] s1_ppn,
   output logic [5:0]  s1_ps,
   output logic [1:0]  s1_plv,
   output logic [1:0]  s1_mat,
   output logic        s1_d,
   output logic        s1_v,
   input  logic        inv_req,
   input  logic [4:0]  inv_op,
   input  logic [9:0]  inv_asid,
   input  logic [18:0] inv_vppn,
   output logic        inv_busy,
   output logic        inv_done
`ifdef TLB_STAT_EN
   ,
   output logic [31:0] stat_hit,
   output logic [31:0] stat_miss
`endif
);

   tlb_entry_t entries_q [TLB_NUM];
   tlb_entry_t entries_d [TLB_NUM];
   tlb_entry_t w_ent;

   inv_state_t     state_q, state_d;
   logic [3:0]     walk_q, walk_d;
   logic [4:0]     op_q, op_d;
   logic [9:0]     asid_q, asid_d;
   logic [18:0]    vppn_q, vppn_d;

   // s0_req only qualifies the fetch lookup upstream; searches are always live.
   logic unused_s0_req;
   assign unused_s0_req = s0_req;

   assign w_ent = '{e: w_e, vppn: w_vppn, ps: w_ps, asid: w_asid, g: w_g,
                    ppn0: w_ppn0, plv0: w_plv0, mat0: w_mat0, d0: w_d0, v0: w_v0,
                    ppn1: w_ppn1, plv1: w_plv1, mat1: w_mat1, d1: w_d1, v1: w_v1};

   // ---------------- entry storage ----------------
   // The walk clears E first and the write port overrides after it, so a
   // write to the entry being walked lands intact.
   always_comb begin
      entries_d = entries_q;
      if (state_q == INV_WALK &&
          inv_pred(entries_q[walk_q], op_q, asid_q, vppn_q)) begin
         entries_d[walk_q].e = 1'b0;
      end
      if (we) begin
         entries_d[w_index] = w_ent;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < TLB_NUM; i++) entries_q[i] <= '0;
      end else begin
         entries_q <= entries_d;
      end
   end

   // ---------------- read port ----------------
   assign r_e    = entries_q[r_index].e;
   assign r_vppn = entries_q[r_index].vppn;
   assign r_ps   = entries_q[r_index].ps;
   assign r_asid = entries_q[r_index].asid;
   assign r_g    = entries_q[r_index].g;
   assign r_ppn0 = entries_q[r_index].ppn0;
   assign r_plv0 = entries_q[r_index].plv0;
   assign r_mat0 = entries_q[r_index].mat0;
   assign r_d0   = entries_q[r_index].d0;
   assign r_v0   = entries_q[r_index].v0;
   assign r_ppn1 = entries_q[r_index].ppn1;
   assign r_plv1 = entries_q[r_index].plv1;
   assign r_mat1 = entries_q[r_index].mat1;
   assign r_d1   = entries_q[r_index].d1;
   assign r_v1   = entries_q[r_index].v1;

   // ---------------- search ports ----------------
   logic [18:0]        s_vppn  [2];
   logic               s_bit12 [2];
   logic [9:0]         s_asid  [2];
   logic [TLB_NUM-1:0] hit     [2];
   logic [TLB_NUM-1:0] odd     [2];

   assign s_vppn[0]  = s0_vppn;
   assign s_vppn[1]  = s1_vppn;
   assign s_bit12[0] = s0_va_bit12;
   assign s_bit12[1] = s1_va_bit12;
   assign s_asid[0]  = s0_asid;
   assign s_asid[1]  = s1_asid;

   for (genvar p = 0; p < 2; p++) begin : g_port
      for (genvar i = 0; i < TLB_NUM; i++) begin : g_ent
         tlb_match u_match (
            .e_i        (entries_q[i].e),
            .g_i        (entries_q[i].g),
            .ent_asid_i (entries_q[i].asid),
            .ent_vppn_i (entries_q[i].vppn),
            .ent_ps_i   (entries_q[i].ps),
            .vppn_i     (s_vppn[p]),
            .va_bit12_i (s_bit12[p]),
            .asid_i     (s_asid[p]),
            .match_o    (hit[p][i]),
            .odd_o      (odd[p][i])
         );
      end
   end

   tlb_entry_t sel_ent   [2];
   logic       sel_odd   [2];
   logic       sel_found [2];
   logic [3:0] sel_idx   [2];

   // Scan high to low so the lowest matching index is the one that sticks.
   // With no match the selected entry stays all-zero, zeroing every field.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         sel_ent[p]   = '0;
         sel_odd[p]   = 1'b0;
         sel_found[p] = 1'b0;
         sel_idx[p]   = '0;
         for (int i = TLB_NUM - 1; i >= 0; i--) begin
            if (hit[p][i]) begin
               sel_ent[p]   = entries_q[i];
               sel_odd[p]   = odd[p][i];
               sel_found[p] = 1'b1;
               sel_idx[p]   = TLB_IDX_W'(i);
            end
         end
      end
   end

   assign s0_found = sel_found[0];
   assign s0_index = sel_idx[0];
   assign s0_ps    = sel_ent[0].ps;
   assign s0_ppn   = sel_odd[0] ? sel_ent[0].ppn1 : sel_ent[0].ppn0;
   assign s0_plv   = sel_odd[0] ? sel_ent[0].plv1 : sel_ent[0].plv0;
   assign s0_mat   = sel_odd[0] ? sel_ent[0].mat1 : sel_ent[0].mat0;
   assign s0_d     = sel_odd[0] ? sel_ent[0].d1   : sel_ent[0].d0;
   assign s0_v     = sel_odd[0] ? sel_ent[0].v1   : sel_ent[0].v0;

   assign s1_found = sel_found[1];
   assign s1_index = sel_idx[1];
   assign s1_ps    = sel_ent[1].ps;
   assign s1_ppn   = sel_odd[1] ? sel_ent[1].ppn1 : sel_ent[1].ppn0;
   assign s1_plv   = sel_odd[1] ? sel_ent[1].plv1 : sel_ent[1].plv0;
   assign s1_mat   = sel_odd[1] ? sel_ent[1].mat1 : sel_ent[1].mat0;
   assign s1_d     = sel_odd[1] ? sel_ent[1].d1   : sel_ent[1].d0;
   assign s1_v     = sel_odd[1] ? sel_ent[1].v1   : sel_ent[1].v0;

   // ---------------- INVTLB walker FSM ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= INV_IDLE;
         walk_q  <= '0;
         op_q    <= '0;
         asid_q  <= '0;
         vppn_q  <= '0;
      end else begin
         state_q <= state_d;
         walk_q  <= walk_d;
         op_q    <= op_d;
         asid_q  <= asid_d;
         vppn_q  <= vppn_d;
      end
   end

   always_comb begin
      state_d = state_q;
      walk_d  = walk_q;
      op_d    = op_q;
      asid_d  = asid_q;
      vppn_d  = vppn_q;
      case (state_q)
         INV_IDLE: begin
            if (inv_req) begin
               op_d   = inv_op;
               asid_d = inv_asid;
               vppn_d = inv_vppn;
               walk_d = '0;
               // Undefined ops change nothing, so skip the walk entirely.
               state_d = (inv_op > INV_GASID_VA) ? INV_DONE : INV_WALK;
            end
         end
         INV_WALK: begin
            walk_d = walk_q + 4'd1;
            if (walk_q == 4'(TLB_NUM - 1)) state_d = INV_DONE;
         end
         INV_DONE: state_d = INV_IDLE;
         default:  state_d = INV_IDLE;
      endcase
   end

   always_comb begin
      inv_busy = (state_q != INV_IDLE);
      inv_done = (state_q == INV_DONE);
   end

   // ---------------- s1 statistics ----------------
`ifdef TLB_STAT_EN
   logic [31:0] hit_q, hit_d, miss_q, miss_d;

   always_comb begin
      hit_d  = hit_q;
      miss_d = miss_q;
      if (s1_req) begin
         if (s1_found) hit_d  = hit_q + 32'd1;
         else          miss_d = miss_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hit_q  <= '0;
         miss_q <= '0;
      end else begin
         hit_q  <= hit_d;
         miss_q <= miss_d;
      end
   end

   assign stat_hit  = hit_q;
   assign stat_miss = miss_q;
`else
   // Without statistics s1_req has no consumer inside the array.
   logic unused_s1_req;
   assign unused_s1_req = s1_req;
`endif

endmodule

// File: tb/tb_tlb_array.sv
module tb_tlb_array;
   logic        clk = 1'b0;
   logic        reset;
   logic        we;
   logic [3:0]  w_index;
   logic        w_e, w_g, w_d0, w_v0, w_d1, w_v1;
   logic [18:0] w_vppn;
   logic [5:0]  w_ps;
   logic [9:0]  w_asid;
   logic [19:0] w_ppn0, w_ppn1;
   logic [1:0]  w_plv0, w_mat0, w_plv1, w_mat1;
   logic [3:0]  r_index;
   logic        r_e, r_g, r_d0, r_v0, r_d1, r_v1;
   logic [18:0] r_vppn;
   logic [5:0]  r_ps;
   logic [9:0]  r_asid;
   logic [19:0] r_ppn0, r_ppn1;
   logic [1:0]  r_plv0, r_mat0, r_plv1, r_mat1;
   logic        s0_req, s0_va_bit12, s0_found, s0_d, s0_v;
   logic [18:0] s0_vppn;
   logic [9:0]  s0_asid;
   logic [3:0]  s0_index;
   logic [19:0] s0_ppn;
   logic [5:0]  s0_ps;
   logic [1:0]  s0_plv, s0_mat;
   logic        s1_req, s1_va_bit12, s1_found, s1_d, s1_v;
   logic [18:0] s1_vppn;
   logic [9:0]  s1_asid;
   logic [3:0]  s1_index;
   logic [19:0] s1_ppn;
   logic [5:0]  s1_ps;
   logic [1:0]  s1_plv, s1_mat;
   logic        inv_req, inv_busy, inv_done;
   logic [4:0]  inv_op;
   logic [9:0]  inv_asid;
   logic [18:0] inv_vppn;
`ifdef TLB_STAT_EN
   logic [31:0] stat_hit, stat_miss;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   tlb_array dut (
      .clk(clk), .reset(reset), .we(we), .w_index(w_index), .w_e(w_e),
      .w_vppn(w_vppn), .w_ps(w_ps), .w_asid(w_asid), .w_g(w_g),
      .w_ppn0(w_ppn0), .w_plv0(w_plv0), .w_mat0(w_mat0), .w_d0(w_d0), .w_v0(w_v0),
      .w_ppn1(w_ppn1), .w_plv1(w_plv1), .w_mat1(w_mat1), .w_d1(w_d1), .w_v1(w_v1),
      .r_index(r_index), .r_e(r_e), .r_vppn(r_vppn), .r_ps(r_ps), .r_asid(r_asid),
      .r_g(r_g), .r_ppn0(r_ppn0), .r_plv0(r_plv0), .r_mat0(r_mat0), .r_d0(r_d0),
      .r_v0(r_v0), .r_ppn1(r_ppn1), .r_plv1(r_plv1), .r_mat1(r_mat1), .r_d1(r_d1),
      .r_v1(r_v1),
      .s0_req(s0_req), .s0_vppn(s0_vppn), .s0_va_bit12(s0_va_bit12), .s0_asid(s0_asid),
      .s0_found(s0_found), .s0_index(s0_index), .s0_ppn(s0_ppn), .s0_ps(s0_ps),
      .s0_plv(s0_plv), .s0_mat(s0_mat), .s0_d(s0_d), .s0_v(s0_v),
      .s1_req(s1_req), .s1_vppn(s1_vppn), .s1_va_bit12(s1_va_bit12), .s1_asid(s1_asid),
      .s1_found(s1_found), .s1_index(s1_index), .s1_ppn(s1_ppn), .s1_ps(s1_ps),
      .s1_plv(s1_plv), .s1_mat(s1_mat), .s1_d(s1_d), .s1_v(s1_v),
      .inv_req(inv_req), .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn),
      .inv_busy(inv_busy), .inv_done(inv_done)
`ifdef TLB_STAT_EN
      , .stat_hit(stat_hit), .stat_miss(stat_miss)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Drive write fields (we untouched). plv/mat/d use fixed markers so the
   // even/odd selection is visible on every field.
   task automatic set_fields(input logic [3:0] idx, input logic [18:0] vppn,
                             input logic [5:0] ps, input logic [9:0] asid,
                             input logic g, input logic [19:0] p0, input logic [19:0] p1,
                             input logic v0, input logic v1);
      w_index = idx; w_e = 1'b1; w_vppn = vppn; w_ps = ps; w_asid = asid; w_g = g;
      w_ppn0 = p0; w_plv0 = 2'd1; w_mat0 = 2'd1; w_d0 = 1'b0; w_v0 = v0;
      w_ppn1 = p1; w_plv1 = 2'd2; w_mat1 = 2'd2; w_d1 = 1'b1; w_v1 = v1;
   endtask

   task automatic wr(input logic [3:0] idx, input logic [18:0] vppn,
                     input logic [5:0] ps, input logic [9:0] asid,
                     input logic g, input logic [19:0] p0, input logic [19:0] p1,
                     input logic v0, input logic v1);
      @(negedge clk);
      set_fields(idx, vppn, ps, asid, g, p0, p1, v0, v1);
      we = 1'b1;
      @(negedge clk);
      we = 1'b0;
   endtask

   task automatic srch1(input logic [18:0] vppn, input logic b12, input logic [9:0] asid);
      s1_vppn = vppn; s1_va_bit12 = b12; s1_asid = asid;
      s0_vppn = vppn; s0_va_bit12 = b12; s0_asid = asid;
      #1;
   endtask

   task automatic rd_e(input logic [3:0] idx, output logic e);
      r_index = idx;
      #1;
      e = r_e;
   endtask

   // Issue one INVTLB and hold inv_req until inv_done. busy_cyc counts cycles
   // with inv_busy=1 up to and including the done cycle. When wr_slot>0, we is
   // raised in the cycle where busy_cyc==wr_slot (walk index wr_slot-1).
   task automatic run_inv(input logic [4:0] op, input logic [9:0] asid,
                          input logic [18:0] vppn, input int wr_slot,
                          output int busy_cyc, output int done_at);
      bit seen;
      @(negedge clk);
      inv_req = 1'b1; inv_op = op; inv_asid = asid; inv_vppn = vppn;
      busy_cyc = 0; done_at = 0; seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         @(negedge clk);
         we = 1'b0;
         if (inv_busy) busy_cyc++;
         if (inv_done) begin
            done_at = busy_cyc;
            seen = 1'b1;
            inv_req = 1'b0;
         end else if (wr_slot > 0 && busy_cyc == wr_slot) begin
            we = 1'b1;
         end
      end
      if (!seen) check("inv_timeout", 64'd0, 64'd1);
      inv_req = 1'b0;
   endtask

   initial begin
      int  busy, dat;
      logic e;
      bit  done_seen;
      reset = 1'b1; we = 1'b0; r_index = '0;
      set_fields(4'd0, '0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
      w_e = 1'b0;
      s0_req = 1'b0; s1_req = 1'b0;
      s0_vppn = '0; s0_va_bit12 = 1'b0; s0_asid = '0;
      s1_vppn = '0; s1_va_bit12 = 1'b0; s1_asid = '0;
      inv_req = 1'b0; inv_op = '0; inv_asid = '0; inv_vppn = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // reset state
      check("rst_busy", inv_busy, 0);
      check("rst_done", inv_done, 0);
      check("rst_s0_found", s0_found, 0);
      check("rst_s1_found", s1_found, 0);
      check("rst_r_e", r_e, 0);
      check("rst_r_ppn0", r_ppn0, 0);

      // 4 KB entry, asid-private
      wr(4'd3, 19'h12345, 6'd12, 10'd5, 1'b0, 20'h11111, 20'hABCDE, 1'b0, 1'b1);
      srch1(19'h12345, 1'b1, 10'd5);
      check("4k_found", s1_found, 1);
      check("4k_index", s1_index, 3);
      check("4k_ppn_odd", s1_ppn, 20'hABCDE);
      check("4k_v_odd", s1_v, 1);
      check("4k_plv_odd", s1_plv, 2);
      check("4k_ps", s1_ps, 12);
      check("4k_s0_ppn", s0_ppn, 20'hABCDE);
      srch1(19'h12345, 1'b0, 10'd5);
      check("4k_ppn_even", s1_ppn, 20'h11111);
      check("4k_v_even", s1_v, 0);
      srch1(19'h12345, 1'b1, 10'd6);
      check("4k_asid_miss", s1_found, 0);
      check("4k_miss_idx", s1_index, 0);
      check("4k_miss_ppn", s1_ppn, 0);
      srch1(19'h12344, 1'b1, 10'd5);
      check("4k_vppn_miss", s0_found, 0);
      r_index = 4'd3; #1;
      check("rd_vppn", r_vppn, 19'h12345);
      check("rd_ppn1", r_ppn1, 20'hABCDE);
      check("rd_asid", r_asid, 5);

      // 2 MB global entry; duplicate at idx12 checks lowest-index priority
      wr(4'd7, 19'h40000, 6'd21, 10'd1, 1'b1, 20'h22222, 20'h33333, 1'b1, 1'b1);
      wr(4'd12, 19'h40000, 6'd21, 10'd1, 1'b1, 20'h44444, 20'h55555, 1'b1, 1'b1);
      srch1(19'h401FF, 1'b0, 10'h3FF);
      check("2m_found", s1_found, 1);
      check("2m_index", s1_index, 7);
      check("2m_ppn_odd", s1_ppn, 20'h33333);
      check("2m_ps", s1_ps, 21);
      srch1(19'h400FF, 1'b1, 10'h3FF);
      check("2m_ppn_even", s0_ppn, 20'h22222);
      check("2m_s0_index", s0_index, 7);

      // undefined op: done right away, nothing changes
      run_inv(5'd9, 10'd0, 19'd0, 0, busy, dat);
      check("op9_busy_cyc", busy, 1);
      check("op9_done_at", dat, 1);
      rd_e(4'd3, e); check("op9_e3", e, 1);
      rd_e(4'd7, e); check("op9_e7", e, 1);

      // op5 asid+va on non-global
      run_inv(5'd5, 10'd5, 19'h12345, 0, busy, dat);
      check("op5_busy_cyc", busy, 17);
      rd_e(4'd3, e);  check("op5_e3", e, 0);
      rd_e(4'd7, e);  check("op5_e7", e, 1);
      rd_e(4'd12, e); check("op5_e12", e, 1);
      @(negedge clk);
      check("op5_idle_busy", inv_busy, 0);
      check("op5_idle_done", inv_done, 0);

      // fill, alternating G, op2 clears the global ones
      for (int i = 0; i < 16; i++)
         wr(4'(i), 19'h100 + 19'(i), 6'd12, 10'd1, (i % 2 == 0), 20'h1, 20'h2, 1'b1, 1'b1);
      run_inv(5'd2, 10'd0, 19'd0, 0, busy, dat);
      check("op2_busy_cyc", busy, 17);
      check("op2_done_at", dat, 17);
      for (int i = 0; i < 16; i++) begin
         rd_e(4'(i), e);
         check($sformatf("op2_e%0d", i), e, (i % 2 == 1));
      end

      // write to the walk's current index wins
      for (int i = 0; i < 16; i++)
         wr(4'(i), 19'h200 + 19'(i), 6'd12, 10'd2, 1'b1, 20'h3, 20'h4, 1'b1, 1'b1);
      set_fields(4'd4, 19'h555, 6'd12, 10'd2, 1'b0, 20'h7, 20'h8, 1'b1, 1'b1);
      run_inv(5'd0, 10'd0, 19'd0, 5, busy, dat);
      for (int i = 0; i < 16; i++) begin
         rd_e(4'(i), e);
         check($sformatf("wwin_e%0d", i), e, (i == 4));
      end
      r_index = 4'd4; #1;
      check("wwin_vppn4", r_vppn, 19'h555);

      // reset mid-walk
      wr(4'd10, 19'h777, 6'd12, 10'd3, 1'b1, 20'h9, 20'hA, 1'b1, 1'b1);
      @(negedge clk);
      inv_req = 1'b1; inv_op = 5'd0;
      repeat (6) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("mrst_busy", inv_busy, 0);
      check("mrst_done", inv_done, 0);
      r_index = 4'd10; #1;
      check("mrst_e10", r_e, 0);
      check("mrst_vppn10", r_vppn, 0);
      srch1(19'h777, 1'b0, 10'd3);
      check("mrst_found", s1_found, 0);
      inv_req = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      done_seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (inv_done) done_seen = 1'b1;
      end
      check("mrst_no_done", done_seen, 0);

`ifdef TLB_STAT_EN
      wr(4'd3, 19'h12345, 6'd12, 10'd5, 1'b0, 20'h11111, 20'hABCDE, 1'b0, 1'b1);
      srch1(19'h12345, 1'b1, 10'd5);
      s1_req = 1'b1;
      repeat (10) @(negedge clk);
      srch1(19'h12345, 1'b1, 10'd6);
      repeat (5) @(negedge clk);
      s1_req = 1'b0;
      repeat (2) @(negedge clk);
      check("stat_hit", stat_hit, 10);
      check("stat_miss", stat_miss, 5);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/tlb_array.md
TLB_ARRAY -- requirements
Module: tlb_array

Interface
REQ-001 clk  in  1  sole clock; all state updates on posedge.
REQ-002 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 we, w_index[3:0], w_e, w_vppn[18:0], w_ps[5:0], w_asid[9:0], w_g  in  write port command and entry header.
REQ-004 w_ppn0/1[19:0], w_plv0/1[1:0], w_mat0/1[1:0], w_d0/1, w_v0/1  in  even/odd page fields.
REQ-005 r_index[3:0]  in, r_e/r_vppn/r_ps/r_asid/r_g/r_ppn0/1/r_plv0/1/r_mat0/1/r_d0/1/r_v0/1  out  read port, same widths as write.
REQ-006 sN_req, sN_vppn[18:0], sN_va_bit12, sN_asid[9:0]  in  (N=0 fetch, N=1 mem/tlbsrch).
REQ-007 sN_found, sN_index[3:0], sN_ppn[19:0], sN_ps[5:0], sN_plv[1:0], sN_mat[1:0], sN_d, sN_v  out  search result.
REQ-008 inv_req, inv_op[4:0], inv_asid[9:0], inv_vppn[18:0]  in  INVTLB command; inv_busy, inv_done  out.

Function
REQ-009 Entry N matches search iff E && (G || asid==sN_asid) && (ps==12 ? vppn==sN_vppn : vppn[18:9]==sN_vppn[18:9]).
REQ-010 Page select: ps==12 uses sN_va_bit12; ps==21 uses sN_vppn[8]; 1 selects odd fields.
REQ-011 Search is combinational, same-cycle; multiple matches return lowest index; no match: found=0, index and fields 0.
REQ-012 Read port is combinational on r_index; reflects writes committed at prior clock edges only.
REQ-013 we=1 writes all fields of entry w_index at the clock edge; visible to search/read next cycle.
REQ-014 INVTLB FSM states IDLE, WALK, DONE; IDLE->WALK on inv_req, latching op/asid/vppn and clearing walk counter.
REQ-015 WALK: one entry per cycle, index 0..15; clear E when predicate true; WALK->DONE after index 15 (16 cycles).
REQ-016 Predicates: op0/1 all; op2 G=1; op3 G=0; op4 G=0&&asid match; op5 G=0&&asid&&vppn match; op6 (G||asid match)&&vppn match; vppn match per REQ-009 rule.
REQ-017 inv_op>6: no entry changed; IDLE->DONE directly.
REQ-018 DONE: inv_done=1 for exactly one cycle, then IDLE; inv_busy=1 in WALK and DONE.
REQ-019 inv_req ignored while inv_busy=1; requester holds inv_req until inv_done.
REQ-020 we during WALK on the walk's current index: write wins, entry not invalidated that cycle; other indices unaffected.
REQ-021 Searches during WALK see partially invalidated array; no stall generated.

Reset
REQ-022 On reset all E=0, all entry fields 0, FSM IDLE, walk counter 0, inv_busy=0, inv_done=0.
REQ-023 Reset during WALK aborts walk; no inv_done pulse is produced.
REQ-024 After reset all sN_found=0 and all read outputs 0.

Configuration
REQ-025 TLB_STAT_EN defined: 32-bit outputs stat_hit/stat_miss count cycles with s1_req=1 and s1_found=1/0; wrap at 2^32; reset to 0.
REQ-026 TLB_STAT_EN undefined: stat ports and counters absent; all other behaviour identical.

Structure
REQ-027 Package tlb_defs holds TLB_NUM=16, TLB_IDX_W=4, PS_4K=12, PS_2M=21, INVTLB op codes 0-6, entry record type.
REQ-028 One sub-module tlb_match: per-entry comparator (match + page select) instanced per search port per entry.

Verification
REQ-029 Write idx3 {E=1,vppn=0x12345,ps=12,asid=5,G=0,ppn1=0xABCDE,v1=1}; search vppn=0x12345,bit12=1,asid=5 -> found=1,index=3,ppn=0xABCDE; asid=6 -> found=0.
REQ-030 Write idx7 ps=21 vppn=0x40000 G=1; search vppn=0x401FF any asid -> found=1,index=7, odd fields selected (vppn[8]=1).
REQ-031 Fill 16 entries, alternate G; inv_op=2 -> inv_busy 17 cycles, inv_done 1 cycle after cycle 16; only G=0 entries keep E=1.
REQ-032 inv_op=5 asid=5 vppn=0x12345 -> only idx3 cleared; inv_op=9 -> done next cycle, array unchanged.
REQ-033 Write idx4 in same cycle WALK reaches 4 under op0 -> idx4 E=1 afterward, all others E=0.
REQ-034 Reset asserted mid-WALK -> all E=0, inv_busy=0 asynchronously, no inv_done; with TLB_STAT_EN 10 hits+5 misses -> stat_hit=10, stat_miss=5.
